// File: rtl/bcd_entry_scan.sv
//------------------------------------------------------------------------------
// Module      : bcd_entry_scan
// Description : N-digit BCD keypad entry register with per-digit decimal
//               one-hot decode and a time-multiplexed scan output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_entry_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_valid,
    input  logic [3:0]                       key_code,
    output logic [4*NUM_DIGITS-1:0]          digits,
    output logic [10*NUM_DIGITS-1:0]         onehot,
    output logic [$clog2(NUM_DIGITS+1)-1:0]  count,
    output logic                             full,
    output logic                             entry_err,
    output logic [NUM_DIGITS-1:0]            scan_sel,
    output logic [9:0]                       scan_onehot
);

    localparam int CW = $clog2(NUM_DIGITS+1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CW-1:0] c_FULL     = CW'(NUM_DIGITS);
    localparam logic [CW-1:0] c_ONE      = CW'(1);
    localparam logic [PW-1:0] c_DIV_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] c_IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [3:0]    c_CLEAR    = 4'd10;
    localparam logic [3:0]    c_BKSP     = 4'd11;

    logic [4*NUM_DIGITS-1:0]  r_digits;
    logic [CW-1:0]            r_count;
    logic                     r_err;
    logic [PW-1:0]            r_presc;
    logic [IW-1:0]            r_idx;
    logic [10*NUM_DIGITS-1:0] w_onehot;
    logic [9:0]               w_scan;

    // Entry register: newest digit always sits in slot 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits <= '1;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (key_valid) begin
                if (key_code <= 4'd9) begin
                    if (r_count < c_FULL) begin
                        r_digits <= {r_digits[4*NUM_DIGITS-5:0], key_code};
                        r_count  <= r_count + c_ONE;
                    end else begin
                        r_err <= 1'b1;
                    end
                end else if (key_code == c_CLEAR) begin
                    r_digits <= '1;
                    r_count  <= '0;
                end else if (key_code == c_BKSP) begin
                    if (r_count != '0) begin
                        r_digits <= {4'hF, r_digits[4*NUM_DIGITS-1:4]};
                        r_count  <= r_count - c_ONE;
                    end else begin
                        r_err <= 1'b1;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Scan prescaler and channel index free-run regardless of key activity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == c_DIV_LAST) begin
            r_presc <= '0;
            r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
            logic [3:0] w_nib;
            assign w_nib = r_digits[4*k +: 4];
            assign w_onehot[10*k +: 10] = (w_nib <= 4'd9) ? (10'd1 << w_nib) : 10'd0;
        end
    endgenerate

    always_comb begin
        w_scan = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_scan = w_onehot[10*k +: 10];
            end
        end
    end

    assign digits      = r_digits;
    assign onehot      = w_onehot;
    assign count       = r_count;
    assign full        = (r_count == c_FULL);
    assign entry_err   = r_err;
    assign scan_sel    = NUM_DIGITS'(1) << r_idx;
    assign scan_onehot = w_scan;

endmodule

`default_nettype wire

// File: tb/tb_bcd_entry_scan.sv
// Self-checking bench for bcd_entry_scan (4 digits, scan divider of 3).
`default_nettype none

module tb_bcd_entry_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [15:0] digits;
    logic [39:0] onehot;
    logic [2:0]  count;
    logic        full;
    logic        entry_err;
    logic [3:0]  scan_sel;
    logic [9:0]  scan_onehot;

    int checks = 0;
    int failures = 0;

    bcd_entry_scan #(.NUM_DIGITS(4), .SCAN_DIV(3)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .digits(digits), .onehot(onehot), .count(count), .full(full),
        .entry_err(entry_err), .scan_sel(scan_sel), .scan_onehot(scan_onehot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] exp_digits;
        logic [2:0]  exp_count;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] dec(input logic [15:0] d);
        logic [39:0] r;
        logic [3:0]  nib;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            nib = d[4*k +: 4];
            if (nib < 4'd10) r[10*k + int'(nib)] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [9:0] dec1(input logic [3:0] nib);
        logic [9:0] r;
        r = '0;
        if (nib < 4'd10) r[nib] = 1'b1;
        return r;
    endfunction

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] d, input logic [2:0] c);
        chk({tag, ".digits"}, 64'(digits), 64'(d));
        chk({tag, ".count"},  64'(count),  64'(c));
        chk({tag, ".full"},   64'(full),   64'(c == 3'd4));
        chk({tag, ".onehot"}, 64'(onehot), 64'(dec(d)));
    endtask

    initial begin
        int idx;
        bit found;
        logic [3:0] exp_sel;
        int cur;

        vecs.push_back('{4'd1,  16'hFFF1, 3'd1, 1'b0});
        vecs.push_back('{4'd2,  16'hFF12, 3'd2, 1'b0});
        vecs.push_back('{4'd3,  16'hF123, 3'd3, 1'b0});
        vecs.push_back('{4'd4,  16'h1234, 3'd4, 1'b0});
        vecs.push_back('{4'd7,  16'h1234, 3'd4, 1'b1});
        vecs.push_back('{4'd11, 16'hF123, 3'd3, 1'b0});
        vecs.push_back('{4'd10, 16'hFFFF, 3'd0, 1'b0});
        vecs.push_back('{4'd11, 16'hFFFF, 3'd0, 1'b1});
        vecs.push_back('{4'd13, 16'hFFFF, 3'd0, 1'b1});
        vecs.push_back('{4'd10, 16'hFFFF, 3'd0, 1'b0});
        vecs.push_back('{4'd9,  16'hFFF9, 3'd1, 1'b0});
        vecs.push_back('{4'd15, 16'hFFF9, 3'd1, 1'b1});
        vecs.push_back('{4'd0,  16'hFF90, 3'd2, 1'b0});
        vecs.push_back('{4'd11, 16'hFFF9, 3'd1, 1'b0});
        vecs.push_back('{4'd11, 16'hFFFF, 3'd0, 1'b0});

        // Reset state
        repeat (3) @(negedge clk);
        chk_state("reset", 16'hFFFF, 3'd0);
        chk("reset.err", 64'(entry_err), 64'd0);
        chk("reset.sel", 64'(scan_sel), 64'd1);
        chk("reset.scan", 64'(scan_onehot), 64'd0);
        rst = 1'b0;

        // Idle: nothing changes, no error, blank scan
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle.err", 64'(entry_err), 64'd0);
            chk("idle.scan", 64'(scan_onehot), 64'd0);
        end
        chk_state("idle", 16'hFFFF, 3'd0);

        // Table-driven key events
        foreach (vecs[i]) begin
            press(vecs[i].code);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_digits, vecs[i].exp_count);
            chk($sformatf("vec%0d.err", i), 64'(entry_err), 64'(vecs[i].exp_err));
            @(negedge clk);
            chk($sformatf("vec%0d.errpulse", i), 64'(entry_err), 64'd0);
            @(negedge clk);
        end

        // Scan sequence with 1234 loaded
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk_state("scanload", 16'h1234, 3'd4);
        found = 1'b0;
        idx = 0;
        exp_sel = scan_sel;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (scan_sel != exp_sel) found = 1'b1;
        end
        chk("scan.edge_found", 64'(found), 64'd1);
        for (int k = 0; k < 4; k++) if (scan_sel == (4'd1 << k)) idx = k;
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            cur = (idx + j / 3) % 4;
            exp_sel = 4'd1 << cur;
            chk($sformatf("scan.sel%0d", j), 64'(scan_sel), 64'(exp_sel));
            chk($sformatf("scan.val%0d", j), 64'(scan_onehot), 64'(dec1(4'(4 - cur))));
        end

        // Reset mid-scan at index 2 while key 5 is being sampled
        press(4'd11);
        chk_state("prerst", 16'hF123, 3'd3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (scan_sel == 4'b0100) found = 1'b1;
        end
        chk("rst.idx2_found", 64'(found), 64'd1);
        key_valid = 1'b1;
        key_code  = 4'd5;
        #4 rst = 1'b1;
        #0.5;
        chk_state("rstasync", 16'hFFFF, 3'd0);
        chk("rstasync.sel", 64'(scan_sel), 64'd1);
        chk("rstasync.scan", 64'(scan_onehot), 64'd0);
        @(negedge clk);
        key_valid = 1'b0;
        chk_state("rsthold", 16'hFFFF, 3'd0);
        chk("rsthold.err", 64'(entry_err), 64'd0);
        rst = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk($sformatf("rel.sel%0d", j), 64'(scan_sel), 64'((j < 3) ? 4'b0001 : 4'b0010));
        end
        chk_state("rel", 16'hFFFF, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_entry_scan.md
Name: bcd_entry_scan

Overview:
- Parametrised successor to the four-channel BCD-to-decimal decoder group, used on the doorlock keypad path.
- Holds an N-digit code-entry register fed by keypad events and supports digit, clear and backspace commands.
- Decodes every held digit to a 10-line one-hot output.
- Time-multiplexes the digits onto a single scan output with a channel select for the display.

Parameters:
- NUM_DIGITS, 4: number of digit channels held and decoded; legal range 2..8.
- SCAN_DIV, 1000: clock cycles each digit stays selected on the scan output; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- key_valid  in  1  single-cycle keypad event strobe.
- key_code  in  4  event code: 0-9 = digit, 10 = clear, 11 = backspace, 12-15 = reserved.
- digits  out  4*NUM_DIGITS  held BCD digits, packed; [3:0] = most recent entry; 4'hF = blank.
- onehot  out  10*NUM_DIGITS  per-digit decimal one-hot; slice k = bits [10k+9:10k], bit n set when digit k == n.
- count  out  $clog2(NUM_DIGITS+1)  number of digits entered.
- full  out  1  high when count == NUM_DIGITS.
- entry_err  out  1  one-cycle pulse on a rejected event.
- scan_sel  out  NUM_DIGITS  one-hot select of the currently scanned digit.
- scan_onehot  out  10  one-hot value of the scanned digit.

Behaviour:
- Reset: asynchronous and active-high, with one clock; it overrides any operation in progress.
  - All digits = 4'hF.
  - count = 0, full = 0, entry_err = 0.
  - onehot = all 0, scan_onehot = 0.
  - scan_sel = 1 (channel 0).
  - Prescaler = 0, scan index = 0.
- Events are sampled only when key_valid = 1; key_code is ignored otherwise.
- Digit event (0-9):
  - If count < NUM_DIGITS: digits shift up one slot, code loads into slot 0, count increments.
  - If full: register is unchanged and entry_err pulses.
- Clear (10): all digits = F and count = 0. It never raises entry_err, including when already empty.
- Backspace (11):
  - If count > 0: digits shift down one slot, top slot loads F, count decrements.
  - If count == 0: no change and entry_err pulses.
- Reserved codes (12-15): no change; entry_err pulses.
- Latency: digits, count, full and entry_err are registered and update on the edge that samples key_valid. They are visible the cycle after the strobe.
- onehot is combinational from the digit register, so it has the same one-cycle latency. Any slot value above 9 (including blank F) decodes to all-zero.
- Scan logic:
  - The prescaler counts 0..SCAN_DIV-1 continuously, independent of key events.
  - On the cycle the prescaler equals SCAN_DIV-1 it wraps to 0, and the scan index advances: k -> k+1, with NUM_DIGITS-1 wrapping to 0.
  - scan_sel = 1 << index.
  - scan_onehot = onehot slice[index], combinational, so a key edit is reflected in the same cycle the register changes.
  - With SCAN_DIV = 1 the index advances every cycle.
- A key event and a scan advance in the same cycle are independent; both take effect.
- The scan cycle also runs while reset is low and the register is empty; blank slots simply drive scan_onehot = 0.

Test Plan:
- Reset, then 20 cycles idle -> digits = 16'hFFFF, count = 0, onehot = 0, scan_sel = 0001, entry_err never set.
- Keys 1,2,3,4 (one per 3 cycles) -> digits = 16'h1234, full = 1; onehot slice0 bit4, slice1 bit3, slice2 bit2, slice3 bit1 set.
- From full, key 7 -> digits unchanged, entry_err high exactly one cycle. Then backspace -> digits = 16'hF123, count = 3, full = 0.
- Backspace on empty, and code 13 -> no state change, entry_err pulses once per event. Clear on empty -> no pulse.
- SCAN_DIV = 3, digits 16'h1234 -> scan_sel cycles 0001,0010,0100,1000,0001, holding each for exactly 3 cycles. scan_onehot = bit4, bit3, bit2, bit1 respectively.
- Assert rst mid-scan (index 2) just as key 5 is sampled -> all outputs return to reset values immediately. The key is lost; scanning restarts at channel 0 after release.
